judge_score_avg: RTL and testbench
==================================

// Module: judge_score_avg
// PURPOSE
//  N-judge scoring unit: accepts one score per submit press and keeps count/sum/max/min.
//  Computes the trimmed average: drops the max and min once >=3 scores are in.
//  Uses a multi-cycle sequential divider and BCD converter; drives a scanned multi-digit 7-seg display.
//  Sits between the switch/button inputs and the display pins; generalises the fixed 7-judge, 4-bit, 2-digit scorer.
// PARAMETERS
//  MAX_JUDGES  7      scores per round (>=3)
//  SCORE_W     4      score width; scores 0..2^SCORE_W-1
//  DIGITS      2      display digits (>=2)
//  SCAN_DIV    50000  scan tick period in clk cycles is SCAN_DIV+1
// PORTS
//  clk      in   1              system clock
//  rst      in   1              synchronous reset, active-high
//  scorein  in   SCORE_W        score value, sampled on the accepted submit edge
//  submit   in   1              raw push-button, asynchronous; its falling edge = submit
//  avg      out  SCORE_W+4      last completed average, binary (tenths when JUDGE_FRAC_EN)
//  count    out  clog2(MAX+1)   scores accepted in the current round
//  full     out  1              count==MAX_JUDGES
//  busy     out  1              divider/BCD pipeline running
//  seg      out  8              seg[7]=dp, seg[6:0]=a..g, active-high
//  sel      out  DIGITS         one-hot digit enable; sel[DIGITS-1]=least significant digit
// BEHAVIOUR
//  Reset: count=0, sum=0, max=0, min=2^SCORE_W-1, avg=0, busy=0, full=0, seg=0, sel=0, scan cnt=0, FSM=IDLE.
//  Submit path: 2-FF synchroniser, then a falling-edge detector gives a 1-cycle pulse sub_p 3 clks after the pin falls.
//  sub_p in IDLE, count<MAX: count+=1, sum+=scorein, max/min updated; next cycle FSM->DIV.
//  sub_p in IDLE, full: clear round (count=0, sum=0, max=0, min=all-ones, avg=0, BCD=0); scorein ignored; no DIV.
//  sub_p while busy: dropped; no state change.
//  Widths: sum is SCORE_W+clog2(MAX_JUDGES+1) bits. Compare and accumulate unsigned; no overflow possible.
//  Dividend/divisor: count>=3 -> (sum-max-min)/(count-2); count 1..2 -> sum/count; count 0 -> 0.
//  Quotient truncates.
//  FSM: IDLE -> DIV (restoring, 1 quotient bit/clk, W_div cycles) -> BCD (repeated /10, DIGITS steps) -> IDLE.
//  busy=1 in DIV and BCD. avg and BCD digits update together on the BCD->IDLE transition; the old value shows until then.
//  Overflow: if the quotient >= 10^DIGITS, every digit shows 'E' (seg=8'b0100_1111); avg still holds the true value.
//  Glyphs: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B (hex, dp=0).
//  Scan: the counter wraps at SCAN_DIV; on the wrap cycle sel rotates one-hot and seg loads that digit's glyph.
//  First tick after reset gives sel[0]=1 (MSD). Order is MSD..LSD, then repeat.
//  Leading zeros are displayed, not blanked.
//  rst mid-DIV/BCD: aborts immediately to reset state; partial results are discarded.
// CONFIGURATION
//  JUDGE_FRAC_EN defined: dividend=trimmed sum*10, so avg is in tenths.
//    The LSD shows tenths; seg[7]=1 while the second-least digit is selected.
//    The divider is widened by 4 bits.
//  JUDGE_FRAC_EN undefined: integer average; seg[7] always 0.
// TESTING
//  1 Reset, SCAN_DIV=4: first tick at cycle 5 -> sel=01, seg=7E. Ticks every 5 clks, alternating sel 01/10.
//  2 Scores 7,8 -> after busy falls: count=2, avg=7, digits "07".
//  3 Scores 3,8,6,7,2,9,5 -> full=1, trimmed 29/5 -> avg=5 "05". With JUDGE_FRAC_EN: avg=58, "5.8".
//  4 8th submit after full -> count=0, avg=0, full=0; busy stays 0.
//  5 Submit edge while busy=1 -> count unchanged. Submit held low, no new edge -> single accept.
//  6 SCORE_W=8, DIGITS=2, single score 200 -> avg=200, display "EE". rst pulse mid-DIV -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/judge_score_avg_if.sv
// Judge scorer pin bundle: switch/button inputs and the results and display outputs.
// The master side drives score and button; the slave side is the scoring unit.
interface judge_score_avg_if #(
    parameter int MAX_JUDGES = 7,
    parameter int SCORE_W    = 4,
    parameter int DIGITS     = 2
);
    localparam int CNT_W = $clog2(MAX_JUDGES + 1);

    logic [SCORE_W-1:0] scorein;
    logic               submit;
    logic [SCORE_W+3:0] avg;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               busy;
    logic [7:0]         seg;
    logic [DIGITS-1:0]  sel;

    modport master (output scorein, submit,
                    input  avg, count, full, busy, seg, sel);
    modport slave  (input  scorein, submit,
                    output avg, count, full, busy, seg, sel);
endinterface

// File: rtl/judge_score_avg.sv
// N-judge scoring unit: accumulates scores, computes a trimmed average with a
// restoring divider, converts to decimal digits and scans a 7-seg display.
// Optional macro JUDGE_FRAC_EN: average in tenths, decimal point before the LSD.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a submit; result and display stable
// S_DIV  | restoring divide, one quotient bit per clock
// S_BCD  | repeated divide-by-10, one digit per clock, LSD first
module judge_score_avg #(
    parameter int MAX_JUDGES = 7,
    parameter int SCORE_W    = 4,
    parameter int DIGITS     = 2,
    parameter int SCAN_DIV   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    judge_score_avg_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_JUDGES + 1);
    localparam int SUM_W = SCORE_W + CNT_W;
`ifdef JUDGE_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif
    localparam int DW   = SUM_W + (FRAC ? 4 : 0);
    localparam int DC_W = $clog2(DW + 1);
    localparam int IX_W = $clog2(DIGITS);
    localparam int SC_W = $clog2(SCAN_DIV + 1);

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction
    localparam int POW10 = pow10(DIGITS);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h7E;  4'd1: glyph = 7'h30;
            4'd2: glyph = 7'h6D;  4'd3: glyph = 7'h79;
            4'd4: glyph = 7'h33;  4'd5: glyph = 7'h5B;
            4'd6: glyph = 7'h5F;  4'd7: glyph = 7'h70;
            4'd8: glyph = 7'h7F;  4'd9: glyph = 7'h7B;
            default: glyph = 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_BCD} state_t;
    state_t state, state_n;

    logic               s1, s2, s3, sub_p, full, accept;
    logic [CNT_W-1:0]   count_r, n_count, dsr, dsr_n, rem, rem_n;
    logic [SUM_W-1:0]   sum_r, n_sum, trim;
    logic [SCORE_W-1:0] max_r, min_r, n_max, n_min;
    logic [DW-1:0]      dq, dq_n, dvd_n, bcd_q;
    logic [CNT_W:0]     trial;
    logic               ge, ovf;
    logic [DC_W-1:0]    div_cnt;
    logic [IX_W-1:0]    bcd_cnt, sel_idx, nidx;
    logic [3:0]         work_dig [DIGITS];
    logic [3:0]         dig_n    [DIGITS];
    logic [3:0]         disp_dig [DIGITS];
    logic               disp_ovf;
    logic [SCORE_W+3:0] avg_r;
    logic [SC_W-1:0]    scan_cnt;
    logic [DIGITS-1:0]  sel_r;
    logic [7:0]         seg_r;

    // Synchronise the raw button; idle level is high so reset does not fake an edge
    always_ff @(posedge clk) begin
        if (rst) {s1, s2, s3} <= 3'b111;
        else     {s1, s2, s3} <= {bus.submit, s1, s2};
    end
    assign sub_p  = s3 & ~s2;
    assign full   = (count_r == CNT_W'(MAX_JUDGES));
    assign accept = sub_p && (state == S_IDLE) && !full;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = S_DIV;
            S_DIV:   if (div_cnt == '0) state_n = S_BCD;
            S_BCD:   if (bcd_cnt == '0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state != S_IDLE);
    end

    // Round update and divider operands; count is never 0 after an accept, so no /0 path
    always_comb begin
        n_count = count_r + CNT_W'(1);
        n_sum   = sum_r + SUM_W'(bus.scorein);
        n_max   = (bus.scorein > max_r) ? bus.scorein : max_r;
        n_min   = (bus.scorein < min_r) ? bus.scorein : min_r;
        trim    = n_sum;
        dsr_n   = n_count;
        if (n_count >= CNT_W'(3)) begin
            trim  = n_sum - SUM_W'(n_max) - SUM_W'(n_min);
            dsr_n = n_count - CNT_W'(2);
        end
        dvd_n = FRAC ? (DW'(trim) << 3) + (DW'(trim) << 1) : DW'(trim);
    end

    // Restoring divide step and BCD digit extraction
    always_comb begin
        trial = {rem, dq[DW-1]};
        ge    = (trial >= {1'b0, dsr});
        rem_n = ge ? CNT_W'(trial - {1'b0, dsr}) : CNT_W'(trial);
        dq_n  = {dq[DW-2:0], ge};
        dig_n = work_dig;
        dig_n[bcd_cnt] = 4'(bcd_q % DW'(10));
        ovf   = (32'(dq) >= 32'(POW10));
    end

    // Round accumulators, divider, BCD converter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            sum_r    <= '0;
            max_r    <= '0;
            min_r    <= '1;
            avg_r    <= '0;
            dq       <= '0;
            dsr      <= '0;
            rem      <= '0;
            div_cnt  <= '0;
            bcd_q    <= '0;
            bcd_cnt  <= '0;
            work_dig <= '{default: 4'd0};
            disp_dig <= '{default: 4'd0};
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (sub_p) begin
                    if (full) begin
                        count_r  <= '0;
                        sum_r    <= '0;
                        max_r    <= '0;
                        min_r    <= '1;
                        avg_r    <= '0;
                        disp_dig <= '{default: 4'd0};
                        disp_ovf <= 1'b0;
                    end else begin
                        count_r <= n_count;
                        sum_r   <= n_sum;
                        max_r   <= n_max;
                        min_r   <= n_min;
                        dq      <= dvd_n;
                        dsr     <= dsr_n;
                        rem     <= '0;
                        div_cnt <= DC_W'(DW - 1);
                    end
                end
                S_DIV: begin
                    dq      <= dq_n;
                    rem     <= rem_n;
                    div_cnt <= div_cnt - DC_W'(1);
                    if (div_cnt == '0) begin
                        bcd_q   <= dq_n;
                        bcd_cnt <= IX_W'(DIGITS - 1);
                    end
                end
                S_BCD: begin
                    bcd_q    <= bcd_q / DW'(10);
                    work_dig <= dig_n;
                    bcd_cnt  <= bcd_cnt - IX_W'(1);
                    if (bcd_cnt == '0) begin
                        disp_dig <= dig_n;
                        disp_ovf <= ovf;
                        avg_r    <= (SCORE_W + 4)'(dq);
                    end
                end
                default: ;
            endcase
        end
    end

    assign nidx = (sel_r == '0 || sel_idx == IX_W'(DIGITS - 1)) ? '0 : sel_idx + IX_W'(1);

    // Display scan: on each wrap advance to the next digit and load its glyph
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel_idx  <= '0;
            sel_r    <= '0;
            seg_r    <= '0;
        end else if (scan_cnt == SC_W'(SCAN_DIV)) begin
            scan_cnt <= '0;
            sel_idx  <= nidx;
            sel_r    <= DIGITS'(1) << nidx;
            if (disp_ovf) seg_r <= 8'b0100_1111;
            else          seg_r <= {FRAC && (nidx == IX_W'(DIGITS - 2)), glyph(disp_dig[nidx])};
        end else begin
            scan_cnt <= scan_cnt + SC_W'(1);
        end
    end

    assign bus.avg   = avg_r;
    assign bus.count = count_r;
    assign bus.full  = full;
    assign bus.seg   = seg_r;
    assign bus.sel   = sel_r;
endmodule

// File: tb/tb_judge_score_avg.sv
// Bench for judge_score_avg: random rounds checked by a scoreboard fed from a
// reference model; display scan and directed corner cases checked alongside.
module tb_judge_score_avg;
    localparam int MAXJ = 7;
    localparam int SW   = 4;
    localparam int SW2  = 8;
    localparam int DG   = 2;
    localparam int SD   = 4;
`ifdef JUDGE_FRAC_EN
    localparam int FR = 1;
`else
    localparam int FR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    judge_score_avg_if #(.MAX_JUDGES(MAXJ), .SCORE_W(SW),  .DIGITS(DG)) bus ();
    judge_score_avg_if #(.MAX_JUDGES(MAXJ), .SCORE_W(SW2), .DIGITS(DG)) bus2 ();

    judge_score_avg #(.MAX_JUDGES(MAXJ), .SCORE_W(SW), .DIGITS(DG), .SCAN_DIV(SD))
        dut (.clk(clk), .rst(rst), .bus(bus));
    judge_score_avg #(.MAX_JUDGES(MAXJ), .SCORE_W(SW2), .DIGITS(DG), .SCAN_DIV(SD))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {int avg; int cnt; int full;} exp_t;
    exp_t sbq[$];
    int   round[$];
    int   errors = 0;
    int   checks = 0;
    int   disp_model [DG];
    bit   disp_ovf_m = 0;
    bit   chk_disp = 1;
    int   mon_idx = -1;
    logic prev_busy = 0;
    logic [DG-1:0] prev_sel = '0;

    function automatic int glyph(input int d);
        int g [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
        return g[d];
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: trimmed mean of the current round, straight from the scoring rules
    function automatic int round_avg();
        int n = round.size();
        int s = 0, mx = 0, mn = 1 << 30, num, d;
        foreach (round[i]) begin
            s += round[i];
            if (round[i] > mx) mx = round[i];
            if (round[i] < mn) mn = round[i];
        end
        if (n == 0) return 0;
        if (n >= 3) begin num = s - mx - mn; d = n - 2; end
        else        begin num = s;           d = n;     end
        if (FR != 0) num = num * 10;
        return num / d;
    endfunction

    function automatic void set_display(input int q);
        disp_ovf_m = (q >= 10 ** DG);
        for (int i = DG - 1; i >= 0; i--) begin
            disp_model[i] = q % 10;
            q = q / 10;
        end
    endfunction

    // Monitor: display ticks and completed averages
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 0;
            prev_sel  = '0;
            mon_idx   = -1;
            set_display(0);
        end else begin
            if (bus.sel != prev_sel) begin
                int nx, es;
                nx = (mon_idx < 0 || mon_idx == DG - 1) ? 0 : mon_idx + 1;
                if (chk_disp) begin
                    es = disp_ovf_m ? 'h4F
                                    : (((FR != 0 && nx == DG - 2) ? 128 : 0) + glyph(disp_model[nx]));
                    check("scan_sel", int'(bus.sel), 1 << nx);
                    check("scan_seg", int'(bus.seg), es);
                end
                mon_idx = nx;
            end
            if (prev_busy && !bus.busy) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("avg",   int'(bus.avg),   e.avg);
                    check("count", int'(bus.count), e.cnt);
                    check("full",  int'(bus.full),  e.full);
                    set_display(e.avg);
                end
            end
            prev_busy = bus.busy;
            prev_sel  = bus.sel;
        end
    end

    task automatic press(input int s, input int low);
        @(negedge clk);
        bus.scorein = SW'(s);
        bus.submit  = 1'b0;
        repeat (low) @(negedge clk);
        bus.submit = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        repeat (4) @(negedge clk);
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("busy_timeout", int'(bus.busy), 0);
    endtask

    task automatic model_accept(input int s);
        exp_t e;
        round.push_back(s);
        e.avg  = round_avg();
        e.cnt  = round.size();
        e.full = (round.size() == MAXJ);
        sbq.push_back(e);
    endtask

    task automatic submit_score(input int s);
        if (round.size() == MAXJ) begin
            chk_disp = 0;
            press(s, 2);
            @(negedge clk);
            check("clr_count", int'(bus.count), 0);
            check("clr_avg",   int'(bus.avg),   0);
            check("clr_full",  int'(bus.full),  0);
            check("clr_busy",  int'(bus.busy),  0);
            round.delete();
            set_display(0);
            @(negedge clk);
            chk_disp = 1;
        end else begin
            model_accept(s);
            press(s, 2);
            wait_idle();
        end
    endtask

    task automatic make_room();
        while (round.size() > MAXJ - 2) submit_score(int'($urandom_range(0, 15)));
    endtask

    initial begin
        int vec [7] = '{3, 8, 6, 7, 2, 9, 5};
        int ticks;
        logic [DG-1:0] ps;
        bus.submit = 1'b1;  bus.scorein = '0;
        bus2.submit = 1'b1; bus2.scorein = '0;
        set_display(0);
        repeat (3) @(negedge clk);
        check("rst_count", int'(bus.count), 0);
        check("rst_avg",   int'(bus.avg),   0);
        check("rst_full",  int'(bus.full),  0);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_seg",   int'(bus.seg),   0);
        check("rst_sel",   int'(bus.sel),   0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_tick_sel", int'(bus.sel), 0);
        @(negedge clk);
        check("first_tick_sel", int'(bus.sel), 1);
        check("first_tick_seg", int'(bus.seg), 'h7E);

        foreach (vec[i]) submit_score(vec[i]);
        submit_score(4);
        submit_score(7);
        submit_score(8);
        repeat (12) @(negedge clk);

        repeat (24) submit_score(int'($urandom_range(0, 15)));

        make_room();
        model_accept(6);
        press(6, 2);
        press(1, 2);
        wait_idle();

        make_room();
        model_accept(11);
        press(11, 40);
        wait_idle();

        bus2.scorein = SW2'(200);
        bus2.submit  = 1'b0;
        repeat (2) @(negedge clk);
        bus2.submit = 1'b1;
        repeat (40) @(negedge clk);
        check("w8_busy",  int'(bus2.busy),  0);
        check("w8_avg",   int'(bus2.avg),   (FR != 0) ? 2000 : 200);
        check("w8_count", int'(bus2.count), 1);
        ticks = 0;
        ps = bus2.sel;
        repeat (12) begin
            @(negedge clk);
            if (bus2.sel != ps) begin
                ticks++;
                check("w8_seg_E", int'(bus2.seg), 'h4F);
            end
            ps = bus2.sel;
        end
        check("w8_ticks_seen", int'(ticks >= 2), 1);

        make_room();
        submit_score(5);
        press(9, 2);
        @(negedge clk);
        check("abort_busy_pre", int'(bus.busy), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_count", int'(bus.count), 0);
        check("abort_avg",   int'(bus.avg),   0);
        check("abort_busy",  int'(bus.busy),  0);
        check("abort_full",  int'(bus.full),  0);
        check("abort_seg",   int'(bus.seg),   0);
        check("abort_sel",   int'(bus.sel),   0);
        rst = 1'b0;
        round.delete();
        repeat (12) @(negedge clk);

        check("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
